id_stage_pipe: RTL and testbench
================================

# id_stage_pipe

Parametrised RV32I decode stage with an integrated register file and the ID/EX pipeline register. It sits between IF and EX in the five-stage core. It decodes the instruction delivered by IF, reads operands with write-back bypass, detects load-use hazards and inserts bubbles. It honours EX back-pressure and branch flushes, and registers all decoded control and data for EX.

## Interface
- XLEN, 32, datapath and PC width
- NREG, 32, architectural register count; 16 selects RV32E, where register indices ≥ NREG are illegal
- WB_BYPASS, 1, 1 makes a same-cycle write-back visible to the operand read
- HAZARD_EN, 1, 1 enables the load-use interlock
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_valid  in  1  IF presents an instruction
- if_instr  in  32  instruction word
- if_pc  in  XLEN  instruction PC
- id_ready  out  1  ID accepts the IF instruction this cycle
- ex_stall  in  1  EX holds; ID/EX must not change
- flush  in  1  taken branch/jump; kill ID/EX contents
- wb_we  in  1  write-back enable
- wb_rd_idx  in  5  write-back register index
- wb_data  in  XLEN  write-back data
- ex_valid  out  1  ID/EX holds a real instruction
- ex_alu_op  out  4  ALU op: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, NOP 1111
- ex_br_op  out  3  branch op: funct3 for branches, UNCOND 010, NOBRA 011
- ex_funct3  out  3  raw funct3, used for memory size/sign
- ex_op1_sel  out  1  0 = rs1, 1 = PC
- ex_op2_sel  out  1  0 = rs2, 1 = imm
- ex_mem_rd, ex_mem_wr  out  1 each  load / store
- ex_wb_sel  out  1  0 = ALU/memory result, 1 = PC+4
- ex_rd_idx, ex_rs1_idx, ex_rs2_idx  out  5 each  register indices
- ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each  operands and sign-extended immediate
- ex_pc, ex_pc4  out  XLEN each  PC and PC+4
- ex_illegal  out  1  undecodable opcode or register index ≥ NREG

## Operation
- Register file: NREG×XLEN. x0 reads 0 and ignores writes. A write occurs on wb_we && wb_rd_idx != 0. All entries clear on reset.
- Bypass: when WB_BYPASS=1 and wb_we && wb_rd_idx == rsN_idx != 0, the read returns wb_data.
- Immediates:
  - I-type/LD/JALR: ImmI
  - shifts: zero-extended shamt
  - ST: ImmS
  - BRA: ImmB
  - LUI/AUIPC: ImmU
  - JAL: ImmJ
  - otherwise 0
- ALU op:
  - R-type: {funct7[5], funct3}
  - I-type: {funct7[5] only for SRAI, else 0, funct3}
  - LD/ST/BRA/JAL/JALR/LUI/AUIPC: ADD
  - illegal: NOP
- ex_op1_sel = 1 for BRA, AUIPC, JAL. For LUI, rs1 index is forced to 0.
- ex_op2_sel = 0 only for R-type.
- ex_rd_idx = 0 for ST and BRA.
- ex_wb_sel = 1 for JAL and JALR.
- rs1 is used by every opcode except LUI, AUIPC, JAL. rs2 is used by R, ST, BRA.
- Hazard: HAZARD_EN && ex_valid && ex_mem_rd && ex_rd_idx != 0 && if_valid && a used rs index equals ex_rd_idx.
- id_ready = !ex_stall && !hazard (combinational).
- ID/EX update priority on each clk edge:
  1. flush: load a bubble.
  2. ex_stall: hold every register.
  3. hazard or !if_valid: load a bubble.
  4. Otherwise: load the decoded instruction with ex_valid=1.
- Bubble: ex_valid=0, alu NOP, br NOBRA, mem_rd/mem_wr 0, rd_idx 0, illegal 0, all other fields 0.
- Illegal instruction: loads with ex_valid=1, ex_illegal=1, alu NOP, br NOBRA, rd 0, no memory access.

## Timing
- Reset (rst low, asynchronous): all outputs 0 except ex_alu_op=1111 and ex_br_op=011. The register file clears.
- Decode latency: 1 cycle from if_* to ex_*.
- Register write is visible to a same-cycle read only when WB_BYPASS=1; otherwise visible from the next cycle.
- Load-use costs exactly one bubble. id_ready is low for one cycle, and the dependent instruction is accepted the next cycle.
- Held operands are not refreshed during ex_stall; EX forwarding covers them.
- flush together with ex_stall: flush wins.
- flush has no effect on id_ready. The IF instruction in a flush cycle is discarded.
- Reset asserted mid-operation clears the pipeline immediately. The first decode occurs on the first edge after rst rises.

## Test plan
- Reset: drive rst low for 2 cycles -> ex_valid=0, ex_alu_op=4'hF, ex_br_op=3'b011; afterwards add x6,x5,x0 gives ex_rs1_data=0.
- Bypass: wb_we=1, wb_rd_idx=5, wb_data=32'hDEADBEEF in the same cycle as 32'h00028333 -> next cycle ex_rs1_data=32'hDEADBEEF, ex_rd_idx=6, ex_alu_op=0000. With WB_BYPASS=0 -> 0.
- Load-use: 32'h00012083 then 32'h001081B3 -> second cycle id_ready=0, next ex_valid=0; the following cycle the add appears with ex_rs1_idx=1.
- Immediates: 32'h4030D093 -> ex_alu_op=1101, ex_imm=3. 32'hFFF00093 -> ex_alu_op=0000, ex_imm=32'hFFFFFFFF.
- JAL at pc 32'h100: 32'h008000EF -> ex_br_op=010, ex_op1_sel=1, ex_wb_sel=1, ex_imm=8, ex_pc4=32'h104.
- Control: ex_stall for 3 cycles -> ex_* unchanged. flush+ex_stall -> bubble. With NREG=16, an instruction using x16 -> ex_illegal=1, ex_alu_op=1111.

Source files
------------

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// id_stage_pipe : RV32I/E decode, register file with WB bypass, load-use
//                 interlock and the ID/EX pipeline register.
// Revision      : 1.0
// ============================================================================
module id_stage_pipe #(
   parameter int XLEN      = 32,
   parameter int NREG      = 32,
   parameter bit WB_BYPASS = 1'b1,
   parameter bit HAZARD_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic            id_ready,
   input  logic            ex_stall,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [4:0]      wb_rd_idx,
   input  logic [XLEN-1:0] wb_data,
   output logic            ex_valid,
   output logic [3:0]      ex_alu_op,
   output logic [2:0]      ex_br_op,
   output logic [2:0]      ex_funct3,
   output logic            ex_op1_sel,
   output logic            ex_op2_sel,
   output logic            ex_mem_rd,
   output logic            ex_mem_wr,
   output logic            ex_wb_sel,
   output logic [4:0]      ex_rd_idx,
   output logic [4:0]      ex_rs1_idx,
   output logic [4:0]      ex_rs2_idx,
   output logic [XLEN-1:0] ex_rs1_data,
   output logic [XLEN-1:0] ex_rs2_data,
   output logic [XLEN-1:0] ex_imm,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_pc4,
   output logic            ex_illegal
);

   localparam int IW = $clog2(NREG);

   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_BRA   = 7'b1100011;
   localparam logic [6:0] OPC_LD    = 7'b0000011;
   localparam logic [6:0] OPC_ST    = 7'b0100011;
   localparam logic [6:0] OPC_OPI   = 7'b0010011;
   localparam logic [6:0] OPC_OP    = 7'b0110011;

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_NOP   = 4'b1111;
   localparam logic [2:0] BR_UNCOND = 3'b010;
   localparam logic [2:0] BR_NOBRA  = 3'b011;

   typedef struct packed {
      logic            valid;
      logic [3:0]      alu_op;
      logic [2:0]      br_op;
      logic [2:0]      funct3;
      logic            op1_sel;
      logic            op2_sel;
      logic            mem_rd;
      logic            mem_wr;
      logic            wb_sel;
      logic [4:0]      rd_idx;
      logic [4:0]      rs1_idx;
      logic [4:0]      rs2_idx;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic            illegal;
   } idex_t;

   function automatic idex_t bubble();
      idex_t b;
      b        = '0;
      b.alu_op = ALU_NOP;
      b.br_op  = BR_NOBRA;
      return b;
   endfunction

   function automatic logic in_range(input logic [4:0] idx);
      return {1'b0, idx} < 6'(NREG);
   endfunction

   logic [XLEN-1:0] rf_q [NREG];
   idex_t           ex_q, ex_d, dec;

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [4:0]      rd, rs1, rs2;
   logic            is_lui, is_auipc, is_jal, is_jalr, is_bra, is_ld, is_st, is_opi, is_op;
   logic            rs1_used, rs2_used, rd_used, illegal, hazard;
   logic [XLEN-1:0] rs1_rf, rs2_rf;

   assign opc      = if_instr[6:0];
   assign f3       = if_instr[14:12];
   assign rd       = if_instr[11:7];
   assign rs2      = if_instr[24:20];
   assign is_lui   = (opc == OPC_LUI);
   assign is_auipc = (opc == OPC_AUIPC);
   assign is_jal   = (opc == OPC_JAL);
   assign is_jalr  = (opc == OPC_JALR);
   assign is_bra   = (opc == OPC_BRA);
   assign is_ld    = (opc == OPC_LD);
   assign is_st    = (opc == OPC_ST);
   assign is_opi   = (opc == OPC_OPI);
   assign is_op    = (opc == OPC_OP);

   // LUI reads x0 so the ALU computes 0 + imm.
   assign rs1      = is_lui ? 5'd0 : if_instr[19:15];
   assign rs1_used = !(is_lui || is_auipc || is_jal);
   assign rs2_used = is_op || is_st || is_bra;
   assign rd_used  = !(is_st || is_bra);

   assign illegal = !(is_lui || is_auipc || is_jal || is_jalr || is_bra ||
                      is_ld || is_st || is_opi || is_op)
                    || (rs1_used && !in_range(rs1))
                    || (rs2_used && !in_range(rs2))
                    || (rd_used  && !in_range(rd));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else if (wb_we && (wb_rd_idx != 5'd0) && in_range(wb_rd_idx)) begin
         rf_q[wb_rd_idx[IW-1:0]] <= wb_data;
      end
   end

   always_comb begin
      rs1_rf = '0;
      rs2_rf = '0;
      if (in_range(rs1)) rs1_rf = rf_q[rs1[IW-1:0]];
      if (in_range(rs2)) rs2_rf = rf_q[rs2[IW-1:0]];
      if (WB_BYPASS && wb_we && (wb_rd_idx == rs1) && (rs1 != 5'd0)) rs1_rf = wb_data;
      if (WB_BYPASS && wb_we && (wb_rd_idx == rs2) && (rs2 != 5'd0)) rs2_rf = wb_data;
   end

   always_comb begin
      dec          = '0;
      dec.valid    = 1'b1;
      dec.funct3   = f3;
      dec.op1_sel  = is_bra || is_auipc || is_jal;
      dec.op2_sel  = !is_op;
      dec.mem_rd   = is_ld;
      dec.mem_wr   = is_st;
      dec.wb_sel   = is_jal || is_jalr;
      dec.rd_idx   = rd_used ? rd : 5'd0;
      dec.rs1_idx  = rs1;
      dec.rs2_idx  = rs2;
      dec.rs1_data = rs1_rf;
      dec.rs2_data = rs2_rf;
      dec.pc       = if_pc;
      dec.pc4      = if_pc + XLEN'(4);
      dec.alu_op   = ALU_ADD;
      dec.br_op    = is_bra ? f3 : ((is_jal || is_jalr) ? BR_UNCOND : BR_NOBRA);
      if (is_op)
         dec.alu_op = {if_instr[30], f3};
      else if (is_opi)
         dec.alu_op = {(f3 == 3'b101) && if_instr[30], f3};

      if (is_opi && (f3 == 3'b001 || f3 == 3'b101))
         dec.imm = XLEN'(if_instr[24:20]);
      else if (is_opi || is_ld || is_jalr)
         dec.imm = XLEN'($signed(if_instr[31:20]));
      else if (is_st)
         dec.imm = XLEN'($signed({if_instr[31:25], if_instr[11:7]}));
      else if (is_bra)
         dec.imm = XLEN'($signed({if_instr[31], if_instr[7], if_instr[30:25],
                                  if_instr[11:8], 1'b0}));
      else if (is_lui || is_auipc)
         dec.imm = XLEN'($signed({if_instr[31:12], 12'b0}));
      else if (is_jal)
         dec.imm = XLEN'($signed({if_instr[31], if_instr[19:12], if_instr[20],
                                  if_instr[30:21], 1'b0}));

      if (illegal) begin
         dec.illegal = 1'b1;
         dec.alu_op  = ALU_NOP;
         dec.br_op   = BR_NOBRA;
         dec.rd_idx  = 5'd0;
         dec.mem_rd  = 1'b0;
         dec.mem_wr  = 1'b0;
      end
   end

   assign hazard = HAZARD_EN && ex_q.valid && ex_q.mem_rd && (ex_q.rd_idx != 5'd0) && if_valid
                   && ((rs1_used && (rs1 == ex_q.rd_idx)) || (rs2_used && (rs2 == ex_q.rd_idx)));

   assign id_ready = !ex_stall && !hazard;

   always_comb begin
      ex_d = ex_q;
      if (flush)
         ex_d = bubble();
      else if (!ex_stall)
         ex_d = (hazard || !if_valid) ? bubble() : dec;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ex_q <= bubble();
      else      ex_q <= ex_d;
   end

   assign ex_valid    = ex_q.valid;
   assign ex_alu_op   = ex_q.alu_op;
   assign ex_br_op    = ex_q.br_op;
   assign ex_funct3   = ex_q.funct3;
   assign ex_op1_sel  = ex_q.op1_sel;
   assign ex_op2_sel  = ex_q.op2_sel;
   assign ex_mem_rd   = ex_q.mem_rd;
   assign ex_mem_wr   = ex_q.mem_wr;
   assign ex_wb_sel   = ex_q.wb_sel;
   assign ex_rd_idx   = ex_q.rd_idx;
   assign ex_rs1_idx  = ex_q.rs1_idx;
   assign ex_rs2_idx  = ex_q.rs2_idx;
   assign ex_rs1_data = ex_q.rs1_data;
   assign ex_rs2_data = ex_q.rs2_data;
   assign ex_imm      = ex_q.imm;
   assign ex_pc       = ex_q.pc;
   assign ex_pc4      = ex_q.pc4;
   assign ex_illegal  = ex_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage_pipe.sv
`default_nettype none
// ============================================================================
// tb_id_stage_pipe : scoreboard bench for id_stage_pipe (default build and an
//                    RV32E build without write-back bypass).
// Revision         : 1.0
// ============================================================================
module tb_id_stage_pipe;

   typedef struct packed {
      logic        ready;
      logic        valid;
      logic [3:0]  alu;
      logic [2:0]  br;
      logic [2:0]  f3;
      logic        op1;
      logic        op2;
      logic        mrd;
      logic        mwr;
      logic        wbs;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        ill;
   } obs_t;

   typedef struct {
      string name;
      obs_t  v;
      obs_t  m;
   } exp_t;

   `define SET(e, f, x) begin e.v.f = x; e.m.f = '1; end

   logic        clk = 1'b0;
   logic        rst, if_valid, ex_stall, flush, wb_we;
   logic [31:0] if_instr, if_pc, wb_data;
   logic [4:0]  wb_rd_idx;

   logic        a_ready, a_valid, a_op1, a_op2, a_mrd, a_mwr, a_wbs, a_ill;
   logic [3:0]  a_alu;
   logic [2:0]  a_br, a_f3;
   logic [4:0]  a_rd, a_rs1, a_rs2;
   logic [31:0] a_d1, a_d2, a_imm, a_pc, a_pc4;
   logic        b_ready, b_valid, b_op1, b_op2, b_mrd, b_mwr, b_wbs, b_ill;
   logic [3:0]  b_alu;
   logic [2:0]  b_br, b_f3;
   logic [4:0]  b_rd, b_rs1, b_rs2;
   logic [31:0] b_d1, b_d2, b_imm, b_pc, b_pc4;
   obs_t        obs_a, obs_b;

   exp_t qa[$];
   exp_t qb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   id_stage_pipe dut_a (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(a_ready), .ex_stall(ex_stall), .flush(flush), .wb_we(wb_we),
      .wb_rd_idx(wb_rd_idx), .wb_data(wb_data), .ex_valid(a_valid), .ex_alu_op(a_alu),
      .ex_br_op(a_br), .ex_funct3(a_f3), .ex_op1_sel(a_op1), .ex_op2_sel(a_op2),
      .ex_mem_rd(a_mrd), .ex_mem_wr(a_mwr), .ex_wb_sel(a_wbs), .ex_rd_idx(a_rd),
      .ex_rs1_idx(a_rs1), .ex_rs2_idx(a_rs2), .ex_rs1_data(a_d1), .ex_rs2_data(a_d2),
      .ex_imm(a_imm), .ex_pc(a_pc), .ex_pc4(a_pc4), .ex_illegal(a_ill)
   );

   id_stage_pipe #(.XLEN(32), .NREG(16), .WB_BYPASS(1'b0), .HAZARD_EN(1'b1)) dut_b (
      .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
      .id_ready(b_ready), .ex_stall(ex_stall), .flush(flush), .wb_we(wb_we),
      .wb_rd_idx(wb_rd_idx), .wb_data(wb_data), .ex_valid(b_valid), .ex_alu_op(b_alu),
      .ex_br_op(b_br), .ex_funct3(b_f3), .ex_op1_sel(b_op1), .ex_op2_sel(b_op2),
      .ex_mem_rd(b_mrd), .ex_mem_wr(b_mwr), .ex_wb_sel(b_wbs), .ex_rd_idx(b_rd),
      .ex_rs1_idx(b_rs1), .ex_rs2_idx(b_rs2), .ex_rs1_data(b_d1), .ex_rs2_data(b_d2),
      .ex_imm(b_imm), .ex_pc(b_pc), .ex_pc4(b_pc4), .ex_illegal(b_ill)
   );

   assign obs_a = {a_ready, a_valid, a_alu, a_br, a_f3, a_op1, a_op2, a_mrd, a_mwr, a_wbs,
                   a_rd, a_rs1, a_rs2, a_d1, a_d2, a_imm, a_pc, a_pc4, a_ill};
   assign obs_b = {b_ready, b_valid, b_alu, b_br, b_f3, b_op1, b_op2, b_mrd, b_mwr, b_wbs,
                   b_rd, b_rs1, b_rs2, b_d1, b_d2, b_imm, b_pc, b_pc4, b_ill};

   function automatic exp_t none();
      exp_t e;
      e.name = "-";
      e.v    = '0;
      e.m    = '0;
      return e;
   endfunction

   function automatic exp_t named(input string n);
      exp_t e;
      e      = none();
      e.name = n;
      return e;
   endfunction

   function automatic exp_t bub(input string n, input logic rdy);
      exp_t e;
      e       = named(n);
      e.v.alu = 4'hF;
      e.v.br  = 3'b011;
      e.v.ready = rdy;
      e.m     = '1;
      return e;
   endfunction

   function automatic exp_t jal_exp(input string n, input logic rdy);
      exp_t e;
      e = named(n);
      e.v = '{ready: rdy, valid: 1'b1, alu: 4'h0, br: 3'b010, f3: 3'b000, op1: 1'b1,
              op2: 1'b1, mrd: 1'b0, mwr: 1'b0, wbs: 1'b1, rd: 5'd1, rs1: 5'd0, rs2: 5'd8,
              d1: 32'h0, d2: 32'h0, imm: 32'h8, pc: 32'h100, pc4: 32'h104, ill: 1'b0};
      e.m = '1;
      return e;
   endfunction

   // Ready is sampled mid-cycle; the ID/EX fields just after the next rising edge.
   task automatic run_monitor(input bit use_b);
      exp_t e;
      obs_t act, tmp;
      forever begin
         @(negedge clk);
         #2;
         if ((use_b ? qb.size() : qa.size()) != 0) begin
            if (use_b) e = qb.pop_front();
            else       e = qa.pop_front();
            act = use_b ? obs_b : obs_a;
            @(posedge clk);
            #1;
            tmp       = use_b ? obs_b : obs_a;
            tmp.ready = act.ready;
            if (e.m != '0) begin
               n_tests++;
               if (((tmp ^ e.v) & e.m) !== '0) begin
                  n_fail++;
                  $display("FAIL %s[%s]: got %h expected %h mask %h",
                           e.name, use_b ? "rv32e" : "base", tmp, e.v, e.m);
               end
            end
         end
      end
   endtask

   initial run_monitor(1'b0);
   initial run_monitor(1'b1);

   task automatic cyc(input logic rs, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic st, input logic fl, input logic we, input logic [4:0] wi,
                      input logic [31:0] wd, input exp_t ea, input exp_t eb);
      @(negedge clk);
      rst = rs; if_valid = v; if_instr = ins; if_pc = pc; ex_stall = st; flush = fl;
      wb_we = we; wb_rd_idx = wi; wb_data = wd;
      qa.push_back(ea);
      qb.push_back(eb);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

   initial begin
      exp_t ea, eb;
      rst = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; ex_stall = 1'b0;
      flush = 1'b0; wb_we = 1'b0; wb_rd_idx = '0; wb_data = '0;

      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, bub("reset0", 1), bub("reset0", 1));
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, bub("reset1", 1), bub("reset1", 1));

      ea = named("add_after_reset");
      `SET(ea, ready, 1'b1) `SET(ea, valid, 1'b1) `SET(ea, rd, 5'd6) `SET(ea, rs1, 5'd5)
      `SET(ea, d1, 32'h0) `SET(ea, alu, 4'h0) `SET(ea, op2, 1'b0) `SET(ea, br, 3'b011)
      `SET(ea, pc4, 32'h4)
      cyc(1, 1, 32'h00028333, 32'h0, 0, 0, 0, 0, 0, ea, ea);

      ea = named("bypass");
      `SET(ea, valid, 1'b1) `SET(ea, rd, 5'd6) `SET(ea, alu, 4'h0) `SET(ea, d1, 32'hDEADBEEF)
      eb = ea;
      `SET(eb, d1, 32'h0)
      cyc(1, 1, 32'h00028333, 32'h4, 0, 0, 1, 5'd5, 32'hDEADBEEF, ea, eb);

      ea = named("write_visible_next");
      `SET(ea, valid, 1'b1) `SET(ea, rd, 5'd6) `SET(ea, d1, 32'hDEADBEEF) `SET(ea, pc, 32'h8)
      cyc(1, 1, 32'h00028333, 32'h8, 0, 0, 0, 0, 0, ea, ea);

      ea = named("load");
      `SET(ea, ready, 1'b1) `SET(ea, valid, 1'b1) `SET(ea, mrd, 1'b1) `SET(ea, rd, 5'd1)
      `SET(ea, rs1, 5'd2) `SET(ea, f3, 3'd2) `SET(ea, op2, 1'b1) `SET(ea, alu, 4'h0)
      `SET(ea, imm, 32'h0) `SET(ea, br, 3'b011)
      cyc(1, 1, 32'h00012083, 32'hC, 0, 0, 0, 0, 0, ea, ea);

      cyc(1, 1, 32'h001081B3, 32'h10, 0, 0, 0, 0, 0,
          bub("loaduse_bubble", 0), bub("loaduse_bubble", 0));

      ea = named("loaduse_accept");
      `SET(ea, ready, 1'b1) `SET(ea, valid, 1'b1) `SET(ea, rs1, 5'd1) `SET(ea, rs2, 5'd1)
      `SET(ea, rd, 5'd3) `SET(ea, alu, 4'h0) `SET(ea, pc, 32'h10)
      cyc(1, 1, 32'h001081B3, 32'h10, 0, 0, 0, 0, 0, ea, ea);

      ea = named("srai");
      `SET(ea, ready, 1'b1) `SET(ea, valid, 1'b1) `SET(ea, alu, 4'hD) `SET(ea, imm, 32'h3)
      `SET(ea, rd, 5'd1) `SET(ea, op2, 1'b1) `SET(ea, f3, 3'd5)
      cyc(1, 1, 32'h4030D093, 32'h14, 0, 0, 0, 0, 0, ea, ea);

      ea = named("addi_neg");
      `SET(ea, valid, 1'b1) `SET(ea, alu, 4'h0) `SET(ea, imm, 32'hFFFFFFFF) `SET(ea, rd, 5'd1)
      `SET(ea, rs1, 5'd0)
      cyc(1, 1, 32'hFFF00093, 32'h18, 0, 0, 0, 0, 0, ea, ea);

      cyc(1, 1, 32'h008000EF, 32'h100, 0, 0, 0, 0, 0, jal_exp("jal", 1), jal_exp("jal", 1));

      for (int i = 0; i < 3; i++)
         cyc(1, 1, 32'hFFF00093, 32'h200, 1, 0, 0, 0, 0,
             jal_exp("stall_hold", 0), jal_exp("stall_hold", 0));

      cyc(1, 1, 32'hFFF00093, 32'h200, 1, 1, 0, 0, 0,
          bub("flush_over_stall", 0), bub("flush_over_stall", 0));
      cyc(1, 1, 32'hFFF00093, 32'h200, 0, 1, 0, 0, 0, bub("flush", 1), bub("flush", 1));
      cyc(1, 0, 32'hFFF00093, 32'h204, 0, 0, 0, 0, 0, bub("no_valid", 1), bub("no_valid", 1));

      ea = named("x16");
      `SET(ea, valid, 1'b1) `SET(ea, ill, 1'b0) `SET(ea, rd, 5'd16) `SET(ea, alu, 4'h0)
      eb = named("x16");
      `SET(eb, valid, 1'b1) `SET(eb, ill, 1'b1) `SET(eb, rd, 5'd0) `SET(eb, alu, 4'hF)
      `SET(eb, br, 3'b011) `SET(eb, mrd, 1'b0) `SET(eb, mwr, 1'b0)
      cyc(1, 1, 32'h00000833, 32'h208, 0, 0, 0, 0, 0, ea, eb);

      ea = named("bad_opcode");
      `SET(ea, valid, 1'b1) `SET(ea, ill, 1'b1) `SET(ea, rd, 5'd0) `SET(ea, alu, 4'hF)
      `SET(ea, br, 3'b011) `SET(ea, mrd, 1'b0) `SET(ea, mwr, 1'b0)
      cyc(1, 1, 32'h0000007F, 32'h20C, 0, 0, 0, 0, 0, ea, ea);

      ea = named("store");
      `SET(ea, valid, 1'b1) `SET(ea, mwr, 1'b1) `SET(ea, mrd, 1'b0) `SET(ea, rd, 5'd0)
      `SET(ea, imm, 32'h4) `SET(ea, rs1, 5'd2) `SET(ea, rs2, 5'd5) `SET(ea, d2, 32'hDEADBEEF)
      `SET(ea, op2, 1'b1) `SET(ea, alu, 4'h0) `SET(ea, br, 3'b011)
      cyc(1, 1, 32'h00512223, 32'h210, 0, 0, 0, 0, 0, ea, ea);

      ea = named("bne");
      `SET(ea, valid, 1'b1) `SET(ea, br, 3'b001) `SET(ea, op1, 1'b1) `SET(ea, imm, 32'h8)
      `SET(ea, rd, 5'd0) `SET(ea, d1, 32'hDEADBEEF) `SET(ea, alu, 4'h0) `SET(ea, pc, 32'h214)
      cyc(1, 1, 32'h00029463, 32'h214, 0, 0, 0, 0, 0, ea, ea);

      cyc(0, 1, 32'h00028333, 32'h218, 0, 0, 0, 0, 0, bub("midreset", 1), bub("midreset", 1));

      ea = named("rf_cleared");
      `SET(ea, valid, 1'b1) `SET(ea, rd, 5'd6) `SET(ea, rs1, 5'd5) `SET(ea, d1, 32'h0)
      cyc(1, 1, 32'h00028333, 32'h0, 0, 0, 0, 0, 0, ea, ea);

      cyc(1, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, none(), none());
      repeat (3) @(negedge clk);

      n_tests++;
      if (qa.size() != 0 || qb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d pending expected 0/0", qa.size(), qb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   `undef SET

endmodule
`default_nettype wire
